mac_rr_scheduler: RTL and testbench
===================================

Name: mac_rr_scheduler

Overview:
- Round-robin scheduler that shares one accumulating MAC datapath among NREQ requesters.
- Each requester streams a K-element dot-product job (operand pairs a,b).
- The scheduler grants the MAC to one requester per whole job, clears the MAC, feeds it, waits for the final accumulated result, and returns that result tagged with the requester id.
- Sits between the matrix-vector front ends and the shared MAC instance.

Parameters:
- NREQ, 2, number of requesters.
- IDW, 1, width of the requester id (ceil(log2(NREQ)), minimum 1).
- K, 4, operand pairs per job.
- KLOG, 3, counter width; must hold the value K.
- W, 8, signed operand width.
- FW, 16, signed result width.

Ports:
- clk, input, 1, clock; all state updates on posedge.
- reset, input, 1, asynchronous active-low reset.
- req_valid, input, NREQ, requester i presents an operand pair.
- req_ready, output, NREQ, one-hot or zero; pair from requester i accepted when req_valid[i] && req_ready[i].
- req_a, input, NREQ*W, packed signed operand a; slice i belongs to requester i.
- req_b, input, NREQ*W, packed signed operand b; slice i belongs to requester i.
- mac_clear, output, 1, registered one-cycle clear pulse to the MAC accumulator.
- mac_valid_in, output, 1, registered; mac_a/mac_b valid this cycle.
- mac_a, output, W, registered operand to the MAC.
- mac_b, output, W, registered operand to the MAC.
- mac_f, input, FW, MAC running accumulation.
- mac_valid_out, input, 1, MAC has produced one accumulation step.
- res_valid, output, 1, result available.
- res_ready, input, 1, consumer accepts the result.
- res_data, output, FW, final accumulated result.
- res_id, output, IDW, id of the requester that owned the job.
- busy, output, 1, high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; rr_ptr=0; owner=0; sent_cnt=0; recv_cnt=0.
  - All outputs 0: req_ready, mac_clear, mac_valid_in, mac_a, mac_b, res_valid, res_data, res_id, busy.
  - Applying reset mid-job abandons the job; no result is emitted.
- States: IDLE, CLEAR, FEED, DRAIN, OUT.
- IDLE:
  - If any req_valid is high, grant the first requester with req_valid high, searching from rr_ptr upward modulo NREQ.
  - Latch owner; go to CLEAR.
  - No req_ready is asserted in IDLE.
- CLEAR (exactly 1 cycle):
  - mac_clear=1 during this cycle; sent_cnt=0, recv_cnt=0.
  - Next state is FEED.
- FEED:
  - req_ready[owner]=1 combinationally while sent_cnt<K; all other req_ready bits are 0.
  - On handshake: next cycle mac_valid_in=1, mac_a/mac_b = owner's slices; sent_cnt increments.
  - Without a handshake, mac_valid_in=0 next cycle (idle cycles are allowed).
  - When sent_cnt reaches K, go to DRAIN.
  - req_valid from non-owners is ignored and never lost; those requesters keep waiting.
- Counting, FEED and DRAIN:
  - Every mac_valid_out pulse increments recv_cnt.
  - On the pulse that makes recv_cnt==K: res_data<=mac_f, res_id<=owner, res_valid<=1, state<=OUT.
  - This transition may happen from DRAIN only; sent_cnt==K is always reached before recv_cnt==K.
- OUT:
  - res_valid held high; res_data and res_id are stable until res_ready.
  - On res_valid && res_ready: res_valid<=0, rr_ptr<=(owner+1) mod NREQ, state<=IDLE.
- Latency:
  - Grant (IDLE→CLEAR) to first req_ready: 2 cycles after the IDLE sample.
  - K-th mac_valid_out to res_valid: 1 cycle.
  - Back-to-back jobs: minimum 1 IDLE cycle between OUT and the next CLEAR.
- Arithmetic: the scheduler does none; res_data is mac_f passed through unchanged at FW bits (signed).
- Fairness: a requester holding req_valid high is granted within NREQ jobs.

Test Plan:
- Single job from req0, a={1,2,3,4}, b={5,6,7,8}, ideal 1-cycle MAC -> exactly one mac_clear, 4 mac_valid_in; res_valid with res_data=70 (16'h0046), res_id=0.
- Signed job from req1, a={-1,-2,-3,-4}, b={5,6,7,8} -> res_data=16'hFFBA (-70), res_id=1.
- req0 and req1 both valid continuously from reset release -> jobs granted in order id 0,1,0,1; req_ready never asserted to both requesters in the same cycle.
- Owner drops req_valid for 3 cycles mid-job -> mac_valid_in low for those cycles; result is still 70; sent_cnt stops at K.
- res_ready held low 5 cycles in OUT -> res_valid stays 1 and res_data/res_id are unchanged; no req_ready asserted; on release, rr_ptr advances and busy returns to 0 next cycle.
- Assert reset low during FEED after 2 pairs -> all outputs 0 immediately; next job from req1 completes normally with the correct result.

Source files
------------

// File: rtl/mac_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : mac_rr_scheduler
//  Purpose  : Round-robin scheduler sharing one accumulating MAC among NREQ
//             requesters. A requester owns the MAC for a whole K-pair job:
//             the accumulator is cleared, the K operand pairs are forwarded,
//             and the final accumulation is returned tagged with the owner id.
//  Ports    : clk, reset (async, active-low)
//             req_valid/req_ready/req_a/req_b : per-requester operand streams
//             mac_clear/mac_valid_in/mac_a/mac_b : registered MAC drive
//             mac_f/mac_valid_out                : MAC accumulation return
//             res_valid/res_ready/res_data/res_id : tagged job result
//             busy : high whenever the scheduler is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module mac_rr_scheduler #(
    parameter int NREQ = 2,
    parameter int IDW  = 1,
    parameter int K    = 4,
    parameter int KLOG = 3,
    parameter int W    = 8,
    parameter int FW   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              mac_clear,
    output logic              mac_valid_in,
    output logic [W-1:0]      mac_a,
    output logic [W-1:0]      mac_b,
    input  logic [FW-1:0]     mac_f,
    input  logic              mac_valid_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [FW-1:0]     res_data,
    output logic [IDW-1:0]    res_id,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } state_t;

    localparam logic [KLOG-1:0] K_CNT  = KLOG'(K);
    localparam logic [KLOG-1:0] K_LAST = KLOG'(K - 1);
    localparam logic [IDW-1:0]  ID_MAX = IDW'(NREQ - 1);

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  owner;
    logic [KLOG-1:0] sent_cnt;
    logic [KLOG-1:0] recv_cnt;

    logic            grant_found;
    logic [IDW-1:0]  grant_id;
    logic            feeding;
    logic            feed_hs;
    logic [IDW-1:0]  next_ptr;

    // Search from rr_ptr upward (mod NREQ). Walking the offsets from the
    // highest down lets the smallest offset with a request win without a break.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[IDW'((int'(rr_ptr) + i) % NREQ)]) begin
                grant_found = 1'b1;
                grant_id    = IDW'((int'(rr_ptr) + i) % NREQ);
            end
        end
    end

    assign feeding  = (state == FEED) && (sent_cnt < K_CNT);
    assign feed_hs  = feeding && req_valid[owner];
    assign next_ptr = (owner == ID_MAX) ? '0 : owner + 1'b1;

    // Only the owner ever sees ready, so non-owner requests simply wait.
    always_comb begin
        req_ready = '0;
        if (feeding) begin
            req_ready[owner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            sent_cnt     <= '0;
            recv_cnt     <= '0;
            mac_clear    <= 1'b0;
            mac_valid_in <= 1'b0;
            mac_a        <= '0;
            mac_b        <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_id       <= '0;
            busy         <= 1'b0;
        end else begin
            // Clear and operand-valid are single-cycle strobes.
            mac_clear    <= 1'b0;
            mac_valid_in <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        owner     <= grant_id;
                        mac_clear <= 1'b1;
                        busy      <= 1'b1;
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    sent_cnt <= '0;
                    recv_cnt <= '0;
                    state    <= FEED;
                end
                FEED, DRAIN: begin
                    if (feed_hs) begin
                        mac_valid_in <= 1'b1;
                        mac_a        <= req_a[owner*W +: W];
                        mac_b        <= req_b[owner*W +: W];
                        sent_cnt     <= sent_cnt + 1'b1;
                        if (sent_cnt == K_LAST) begin
                            state <= DRAIN;
                        end
                    end
                    if (mac_valid_out) begin
                        recv_cnt <= recv_cnt + 1'b1;
                        // All K pairs have been sent before the last step
                        // can return, so completion is only taken in DRAIN.
                        if ((state == DRAIN) && (recv_cnt == K_LAST)) begin
                            res_data  <= mac_f;
                            res_id    <= owner;
                            res_valid <= 1'b1;
                            state     <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        rr_ptr    <= next_ptr;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_rr_scheduler
//  Purpose  : Self-checking bench for mac_rr_scheduler with an ideal
//             one-cycle accumulating MAC model and a result scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mac_rr_scheduler;

    localparam int NREQ = 2;
    localparam int IDW  = 1;
    localparam int K    = 4;
    localparam int KLOG = 3;
    localparam int W    = 8;
    localparam int FW   = 16;
    localparam int TMO  = 100;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              mac_clear;
    logic              mac_valid_in;
    logic [W-1:0]      mac_a;
    logic [W-1:0]      mac_b;
    logic [FW-1:0]     mac_f;
    logic              mac_valid_out;
    logic              res_valid;
    logic              res_ready;
    logic [FW-1:0]     res_data;
    logic [IDW-1:0]    res_id;
    logic              busy;

    mac_rr_scheduler #(
        .NREQ(NREQ), .IDW(IDW), .K(K), .KLOG(KLOG), .W(W), .FW(FW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .mac_clear    (mac_clear),
        .mac_valid_in (mac_valid_in),
        .mac_a        (mac_a),
        .mac_b        (mac_b),
        .mac_f        (mac_f),
        .mac_valid_out(mac_valid_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_id       (res_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Ideal MAC: one accumulation step per operand pair, one cycle later.
    logic signed [FW-1:0] acc;
    logic signed [FW-1:0] pa;
    logic signed [FW-1:0] pb;
    logic                 vout;
    assign pa = FW'($signed(mac_a));
    assign pb = FW'($signed(mac_b));
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc  <= '0;
            vout <= 1'b0;
        end else begin
            vout <= mac_valid_in;
            if (mac_clear) begin
                acc <= '0;
            end else if (mac_valid_in) begin
                acc <= acc + pa * pb;
            end
        end
    end
    assign mac_f         = acc;
    assign mac_valid_out = vout;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [K*W-1:0] a;
        logic [K*W-1:0] b;
        logic [FW-1:0]  exp;
    } vec_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [FW-1:0]  data;
    } exp_t;

    vec_t tab [6];
    exp_t sb [$];
    exp_t mon_e;

    int n_checks  = 0;
    int n_fail    = 0;
    int cnt_clear = 0;
    int cnt_vin   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int id, input int a0, input int a1, input int a2, input int a3,
                                input int b0, input int b1, input int b2, input int b3,
                                input logic [FW-1:0] e);
        vec_t v;
        v.id  = IDW'(id);
        v.a   = {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
        v.b   = {8'(b3), 8'(b2), 8'(b1), 8'(b0)};
        v.exp = e;
        return v;
    endfunction

    function automatic exp_t mk_exp(input int id, input logic [FW-1:0] d);
        exp_t e;
        e.id   = IDW'(id);
        e.data = d;
        return e;
    endfunction

    // Output monitor: one-hot ready, strobe counters, result scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            check("ready_onehot", 32'($countones(req_ready) <= 1), 32'(1));
            if (mac_clear)    cnt_clear++;
            if (mac_valid_in) cnt_vin++;
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got id=%0d data=%0h, expected no result", res_id, res_data);
                end else begin
                    mon_e = sb.pop_front();
                    check("res_data", 32'(res_data), 32'(mon_e.data));
                    check("res_id",   32'(res_id),   32'(mon_e.id));
                end
            end
        end
    end

    // Stream up to max_pairs pairs of vector vec from requester id, njobs times.
    // Optionally drop valid for gap_len cycles before pair gap_at of the first job.
    task automatic feed(input int id, input int vec, input int njobs,
                        input int gap_at, input int gap_len, input int max_pairs);
        int t;
        for (int j = 0; j < njobs; j++) begin
            for (int n = 0; n < max_pairs; n++) begin
                if (j == 0 && n == gap_at) begin
                    @(negedge clk);
                    req_valid[id] = 1'b0;
                    repeat (gap_len) begin
                        @(posedge clk);
                        #1;
                        check("gap_vin_low", 32'(mac_valid_in), 32'(0));
                    end
                end
                @(negedge clk);
                req_a[id*W +: W] = tab[vec].a[n*W +: W];
                req_b[id*W +: W] = tab[vec].b[n*W +: W];
                req_valid[id]    = 1'b1;
                t = 0;
                while (!req_ready[id] && t < TMO) begin
                    @(posedge clk);
                    @(negedge clk);
                    t++;
                end
                check("feed_ready_seen", 32'(t < TMO), 32'(1));
                @(posedge clk);
            end
        end
        @(negedge clk);
        req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("drain_done", 32'(sb.size()), 32'(0));
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_c, base_v, t;
        tab[0] = mk(0,    1,    2, 3,  4,    5,    6, 7,  8, 16'h0046);
        tab[1] = mk(1,   -1,   -2, -3, -4,   5,    6, 7,  8, 16'hFFBA);
        tab[2] = mk(0,  127,  127, 127, 127, 127, 127, 127, 127, 16'hFC04);
        tab[3] = mk(1, -128, -128, -128, -128, -128, -128, -128, -128, 16'h0000);
        tab[4] = mk(0, -128,  127, 0,  1,  127, -128, 5, -1, 16'h80FF);
        tab[5] = mk(1,    0,    0, 0,  0,    1,    2, 3,  4, 16'h0000);

        reset     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy",      32'(busy),         32'(0));
        check("rst_req_ready", 32'(req_ready),    32'(0));
        check("rst_mac_clear", 32'(mac_clear),    32'(0));
        check("rst_mac_vin",   32'(mac_valid_in), 32'(0));
        check("rst_mac_a",     32'(mac_a),        32'(0));
        check("rst_mac_b",     32'(mac_b),        32'(0));
        check("rst_res_valid", 32'(res_valid),    32'(0));
        check("rst_res_data",  32'(res_data),     32'(0));
        check("rst_res_id",    32'(res_id),       32'(0));

        // Both requesters valid from reset release: grants alternate 0,1,0,1.
        sb.push_back(mk_exp(0, 16'h0046));
        sb.push_back(mk_exp(1, 16'hFFBA));
        sb.push_back(mk_exp(0, 16'h0046));
        sb.push_back(mk_exp(1, 16'hFFBA));
        req_a[0 +: W] = tab[0].a[0 +: W];
        req_b[0 +: W] = tab[0].b[0 +: W];
        req_a[W +: W] = tab[1].a[0 +: W];
        req_b[W +: W] = tab[1].b[0 +: W];
        req_valid     = 2'b11;
        @(negedge clk);
        reset = 1'b1;
        fork
            feed(0, 0, 2, -1, 0, K);
            feed(1, 1, 2, -1, 0, K);
        join
        drain();

        // Table-driven single jobs
        for (int v = 0; v < 6; v++) begin
            base_c = cnt_clear;
            base_v = cnt_vin;
            sb.push_back(mk_exp(int'(tab[v].id), tab[v].exp));
            feed(int'(tab[v].id), v, 1, -1, 0, K);
            drain();
            check("job_clear_cnt", 32'(cnt_clear - base_c), 32'(1));
            check("job_vin_cnt",   32'(cnt_vin - base_v),   32'(K));
        end

        // Owner stalls 3 cycles after 2 pairs
        base_c = cnt_clear;
        base_v = cnt_vin;
        sb.push_back(mk_exp(0, 16'h0046));
        feed(0, 0, 1, 2, 3, K);
        drain();
        check("gap_clear_cnt", 32'(cnt_clear - base_c), 32'(1));
        check("gap_vin_cnt",   32'(cnt_vin - base_v),   32'(K));

        // Result held in OUT while res_ready low
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        sb.push_back(mk_exp(0, 16'h0046));
        feed(0, 0, 1, -1, 0, K);
        t = 0;
        while (!res_valid && t < TMO) begin
            @(negedge clk);
            t++;
        end
        check("hold_res_seen", 32'(res_valid), 32'(1));
        repeat (5) begin
            @(negedge clk);
            check("hold_res_valid", 32'(res_valid), 32'(1));
            check("hold_res_data",  32'(res_data),  32'(16'h0046));
            check("hold_res_id",    32'(res_id),    32'(0));
            check("hold_req_ready", 32'(req_ready), 32'(0));
            check("hold_busy",      32'(busy),      32'(1));
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_busy", 32'(busy), 32'(0));
        check("release_sb",   32'(sb.size()), 32'(0));

        // rr_ptr advanced past requester 0: with both pending, 1 goes first.
        sb.push_back(mk_exp(1, 16'hFFBA));
        sb.push_back(mk_exp(0, 16'h0046));
        fork
            feed(0, 0, 1, -1, 0, K);
            feed(1, 1, 1, -1, 0, K);
        join
        drain();

        // Reset mid-FEED after two pairs: job abandoned, no result.
        feed(0, 0, 1, -1, 0, 2);
        check("abort_busy_before", 32'(busy), 32'(1));
        reset = 1'b0;
        #1;
        check("abort_busy",      32'(busy),         32'(0));
        check("abort_req_ready", 32'(req_ready),    32'(0));
        check("abort_mac_clear", 32'(mac_clear),    32'(0));
        check("abort_mac_vin",   32'(mac_valid_in), 32'(0));
        check("abort_mac_a",     32'(mac_a),        32'(0));
        check("abort_mac_b",     32'(mac_b),        32'(0));
        check("abort_res_valid", 32'(res_valid),    32'(0));
        check("abort_res_data",  32'(res_data),     32'(0));
        check("abort_res_id",    32'(res_id),       32'(0));
        @(negedge clk);
        reset = 1'b1;
        sb.push_back(mk_exp(1, 16'hFFBA));
        feed(1, 1, 1, -1, 0, K);
        drain();

        repeat (5) @(negedge clk);
        check("final_sb_empty", 32'(sb.size()), 32'(0));
        check("final_busy",     32'(busy),      32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
